// File: rtl/debounce_scan_core.sv
// W-channel input debouncer: one shared integration engine is swept across the
// channels (one per clock) each time the programmable sample divider ticks.
module debounce_scan_core #(
    parameter int              W       = 8,
    parameter int              CW      = 20,
    parameter logic [CW-1:0]   DIV_RST = 20'd999_999,
    parameter int              THR     = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cs,
    input  logic          i_read,
    input  logic          i_write,
    input  logic [4:0]    i_addr,
    input  logic [31:0]   i_wr_data,
    output logic [31:0]   o_rd_data,
    input  logic [W-1:0]  i_din,
    output logic          o_irq
);
    localparam int CNT_W = $clog2(THR);
    localparam int IW    = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    logic [W-1:0]  r_sync1, r_sync2;
    logic [W-1:0]  r_db, r_rise, r_fall, r_mask;
    logic [CW-1:0] r_divisor, r_div_cnt;
    logic          r_irq;
    state_t        r_state, w_state_next;
    logic [IW-1:0] r_idx, w_idx_next;

    logic          w_wr, w_wr_rise, w_wr_fall, w_wr_div, w_wr_mask;
    logic [CW-1:0] w_div_eff;
    logic          w_tick, w_scan;
    logic [W-1:0]  w_flip, w_rise_clr, w_fall_clr;
    logic          w_unused;

    assign w_wr      = i_cs & i_write;
    assign w_wr_rise = w_wr && (i_addr == 5'd2);
    assign w_wr_fall = w_wr && (i_addr == 5'd3);
    assign w_wr_div  = w_wr && (i_addr == 5'd4);
    assign w_wr_mask = w_wr && (i_addr == 5'd5);
    assign w_unused  = &{1'b0, i_read, i_wr_data};

    // Clamping the period to at least W keeps a new tick out of a running scan.
    assign w_div_eff = (r_divisor < CW'(W)) ? CW'(W) : r_divisor;
    assign w_tick    = (r_div_cnt >= w_div_eff);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_divisor <= DIV_RST;
            r_div_cnt <= '0;
        end else if (w_wr_div) begin
            r_divisor <= i_wr_data[CW-1:0];
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_SCAN;
                    w_idx_next   = '0;
                end
            end
            S_SCAN: begin
                if (r_idx == IW'(W - 1)) begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + IW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_scan = (r_state == S_SCAN);
    end

    // Each channel keeps only its integration count; the comparison logic is
    // enabled for exactly one channel per scan clock.
    for (genvar gi = 0; gi < W; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             w_sel, w_diff;

        assign w_sel       = w_scan && (r_idx == IW'(gi));
        assign w_diff      = r_sync2[gi] ^ r_db[gi];
        assign w_flip[gi]  = w_sel && w_diff && (r_cnt == CNT_W'(THR - 1));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
            end else if (w_sel) begin
                if (!w_diff || w_flip[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise_clr = w_wr_rise ? i_wr_data[W-1:0] : '0;
    assign w_fall_clr = w_wr_fall ? i_wr_data[W-1:0] : '0;

    // New events are OR-ed in after the clear so a simultaneous set survives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_db   <= r_db ^ w_flip;
            r_rise <= (r_rise & ~w_rise_clr) | (w_flip & ~r_db);
            r_fall <= (r_fall & ~w_fall_clr) | (w_flip & r_db);
            r_irq  <= |((r_rise | r_fall) & r_mask);
            if (w_wr_mask) begin
                r_mask <= i_wr_data[W-1:0];
            end
        end
    end

    assign o_irq = r_irq;

    always_comb begin
        o_rd_data = '0;
        case (i_addr)
            5'd0:    o_rd_data[W-1:0]  = r_sync2;
            5'd1:    o_rd_data[W-1:0]  = r_db;
            5'd2:    o_rd_data[W-1:0]  = r_rise;
            5'd3:    o_rd_data[W-1:0]  = r_fall;
            5'd4:    o_rd_data[CW-1:0] = r_divisor;
            5'd5:    o_rd_data[W-1:0]  = r_mask;
            default: o_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_debounce_scan_core.sv
// Bench for debounce_scan_core: register vectors, timed corner sequences and a
// randomized run, all checked every cycle against an event-schedule model.
module tb_debounce_scan_core;
    localparam int            W       = 8;
    localparam int            CW      = 20;
    localparam int            THR     = 4;
    localparam logic [CW-1:0] DIV_RST = 20'd999_999;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs    = 1'b0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic [4:0]    addr  = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [W-1:0]  din   = '0;
    logic          irq;

    always #10 clk = ~clk;

    debounce_scan_core #(.W(W), .CW(CW), .DIV_RST(DIV_RST), .THR(THR)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cs      (cs),
        .i_read    (rd),
        .i_write   (wr),
        .i_addr    (addr),
        .i_wr_data (wdata),
        .o_rd_data (rdata),
        .i_din     (din),
        .o_irq     (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rv [8];

    // Reference model: cycle index since reset release, tick times derived
    // arithmetically, and a schedule of which channel is sampled on which cycle.
    int            m_n, m_last_zero;
    logic [CW-1:0] m_div;
    logic [W-1:0]  m_db, m_rise, m_fall, m_mask;
    logic [W-1:0]  m_hist [4];
    logic          m_irq;
    int            m_run [W];
    int            m_scan_at [64];

    task automatic model_reset();
        m_n = 0; m_last_zero = 0; m_div = DIV_RST;
        m_db = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_irq = 1'b0;
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
        for (int k = 0; k < W; k++) m_run[k] = 0;
        for (int k = 0; k < 64; k++) m_scan_at[k] = -1;
    endtask

    function automatic logic [W-1:0] model_sync();
        return (m_n >= 2) ? m_hist[(m_n - 2) % 4] : '0;
    endfunction

    task automatic model_step();
        logic [W-1:0] s, set_r, set_f, clr_r, clr_f;
        int de, ch;
        s = model_sync();
        m_hist[m_n % 4] = din;
        de = (int'(m_div) < W) ? W : int'(m_div);
        if ((m_n - m_last_zero) % (de + 1) == de)
            for (int i = 0; i < W; i++) m_scan_at[(m_n + 1 + i) % 64] = i;
        set_r = '0; set_f = '0; clr_r = '0; clr_f = '0;
        ch = m_scan_at[m_n % 64];
        if (ch >= 0) begin
            m_scan_at[m_n % 64] = -1;
            if (s[ch] != m_db[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == THR) begin
                    m_run[ch] = 0;
                    if (m_db[ch]) set_f[ch] = 1'b1;
                    else          set_r[ch] = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        m_irq = |((m_rise | m_fall) & m_mask);
        if (cs && wr) begin
            case (addr)
                5'd2: clr_r = wdata[W-1:0];
                5'd3: clr_f = wdata[W-1:0];
                5'd4: begin m_div = wdata[CW-1:0]; m_last_zero = m_n + 1; end
                5'd5: m_mask = wdata[W-1:0];
                default: ;
            endcase
        end
        m_rise = (m_rise & ~clr_r) | set_r;
        m_fall = (m_fall & ~clr_f) | set_f;
        m_db   = m_db ^ (set_r | set_f);
        m_n++;
    endtask

    function automatic logic [31:0] model_rd(input int a);
        logic [31:0] v;
        v = '0;
        case (a)
            0: v[W-1:0]  = model_sync();
            1: v[W-1:0]  = m_db;
            2: v[W-1:0]  = m_rise;
            3: v[W-1:0]  = m_fall;
            4: v[CW-1:0] = m_div;
            5: v[W-1:0]  = m_mask;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int a = 0; a < 8; a++) begin
            addr = 5'(a);
            #1;
            rv[a] = rdata;
            chk($sformatf("model_reg%0d", a), rdata, model_rd(a));
        end
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d);
        cs = w; wr = w; addr = a; wdata = d;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk_reset_regs(input string tag);
        for (int a = 0; a < 8; a++)
            chk($sformatf("%s_reg%0d", tag, a), rv[a], (a == 4) ? 32'h000F_423F : 32'h0);
        chk($sformatf("%s_irq", tag), 32'(irq), 32'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [11];

    initial begin
        int first [W];
        logic [W-1:0] db0;
        int b, r;

        vt[0]  = '{1'b1, 5'd5,  32'h0000_00A5, 32'h0000_00A5};
        vt[1]  = '{1'b1, 5'd4,  32'h0001_2345, 32'h0001_2345};
        vt[2]  = '{1'b1, 5'd4,  32'hFFF0_03E8, 32'h0000_03E8};
        vt[3]  = '{1'b1, 5'd6,  32'hDEAD_BEEF, 32'h0000_0000};
        vt[4]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[5]  = '{1'b1, 5'd0,  32'h0000_00FF, 32'h0000_0000};
        vt[6]  = '{1'b1, 5'd1,  32'h0000_00FF, 32'h0000_0000};
        vt[7]  = '{1'b1, 5'd2,  32'h0000_00FF, 32'h0000_0000};
        vt[8]  = '{1'b1, 5'd5,  32'hFFFF_FF3C, 32'h0000_003C};
        vt[9]  = '{1'b0, 5'd4,  32'h0000_0000, 32'h0000_03E8};
        vt[10] = '{1'b1, 5'd5,  32'h0000_0000, 32'h0000_0000};

        // Reset held with all inputs high.
        din = 8'hFF; rst_n = 1'b0; model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk_reset_regs("reset");
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 32'h0);
        chk("sync_1clk", rv[0], 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        chk("sync_2clk", rv[0], 32'hFF);
        chk("db_after_rel", rv[1], 32'h0);
        $display("[TB] reset sequence done");

        din = 8'h00;
        idle(3);
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].wr, vt[i].a, vt[i].d);
            addr = vt[i].a;
            #1;
            chk($sformatf("vec%0d", i), rdata, vt[i].exp);
            $display("[TB] vec %0d wr=%0b addr=%0d data=%h read=%h", i, vt[i].wr, vt[i].a, vt[i].d, rdata);
        end

        // Clean press on channel 3.
        cyc(1'b1, 5'd4, 32'd20);
        din = 8'h08;
        idle(130);
        chk("press_db", rv[1], 32'h08);
        chk("press_rise", rv[2], 32'h08);
        chk("press_fall", rv[3], 32'h00);
        chk("press_irq_masked", 32'(irq), 32'h0);
        cyc(1'b1, 5'd5, 32'h08);
        idle(1);
        chk("press_irq_unmasked", 32'(irq), 32'h1);
        $display("[TB] clean press done db=%h rise=%h", rv[1], rv[2]);

        // Bouncing channel 0, then stable high.
        cyc(1'b1, 5'd2, 32'hFF);
        cyc(1'b1, 5'd3, 32'hFF);
        for (int k = 0; k < 200; k++) begin
            if (k % 15 == 0) din[0] = ~din[0];
            cyc(1'b0, 5'd0, 32'h0);
        end
        chk("bounce_no_rise", rv[2], 32'h0);
        chk("bounce_no_fall", rv[3], 32'h0);
        din[0] = 1'b1;
        idle(150);
        chk("bounce_one_rise", rv[2], 32'h01);
        chk("bounce_fall", rv[3], 32'h0);
        chk("bounce_db", rv[1], 32'h09);
        $display("[TB] bounce done rise=%h", rv[2]);

        // Clamped divisor: channel i flips at write cycle + 38 + i.
        cyc(1'b1, 5'd4, 32'd1000);
        idle(10);
        din = 8'hF6;
        idle(4);
        db0 = 8'h09;
        cyc(1'b1, 5'd4, 32'd2);
        for (int i = 0; i < W; i++) first[i] = -1;
        for (int k = 1; k <= 50; k++) begin
            if (k > 1) cyc(1'b0, 5'd0, 32'h0);
            for (int i = 0; i < W; i++)
                if (first[i] < 0 && rv[1][i] != db0[i]) first[i] = k;
        end
        for (int i = 0; i < W; i++)
            chk($sformatf("scan_order_ch%0d", i), 32'(first[i]), 32'(38 + i));
        $display("[TB] clamp/scan order done db=%h", rv[1]);

        // W1C on the very cycle rise[3] is set, then a plain W1C.
        cyc(1'b1, 5'd4, 32'd1000);
        idle(10);
        cyc(1'b1, 5'd2, 32'hFF);
        cyc(1'b1, 5'd3, 32'hFF);
        din = 8'hFE;
        idle(4);
        cyc(1'b1, 5'd4, 32'd2);
        idle(39);
        cyc(1'b1, 5'd2, 32'h08);
        chk("w1c_race_flag", rv[2], 32'h08);
        cyc(1'b1, 5'd2, 32'h08);
        chk("w1c_clear_flag", rv[2], 32'h00);
        chk("w1c_irq_still", 32'(irq), 32'h1);
        cyc(1'b0, 5'd0, 32'h0);
        chk("w1c_irq_drop", 32'(irq), 32'h0);
        $display("[TB] w1c race done");

        // Reset asserted while the scan is at channel 4.
        din = 8'h01;
        idle(3);
        cyc(1'b1, 5'd4, 32'd2);
        idle(13);
        rst_n = 1'b0;
        model_reset();
        check_all();
        chk_reset_regs("midscan");
        idle(2);
        rst_n = 1'b1;
        idle(60);
        chk("post_rst_rise", rv[2], 32'h0);
        chk("post_rst_fall", rv[3], 32'h0);
        chk("post_rst_db", rv[1], 32'h0);
        $display("[TB] mid-scan reset done");

        // Randomized traffic against the model.
        cyc(1'b1, 5'd4, 32'd10);
        cyc(1'b1, 5'd5, $urandom());
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                b = $urandom_range(0, W - 1);
                din[b] = ~din[b];
            end
            r = $urandom_range(0, 99);
            if (r < 3)
                cyc(1'b1, 5'($urandom_range(2, 3)), $urandom());
            else if (r == 3)
                cyc(1'b1, 5'd5, $urandom());
            else if (r == 4 && $urandom_range(0, 9) == 0)
                cyc(1'b1, 5'd4, ($urandom() & 32'hFFF0_0000) | 32'($urandom_range(0, 30)));
            else if (r == 5)
                cyc(1'b1, 5'($urandom_range(6, 31)), $urandom());
            else
                cyc(1'b0, 5'($urandom_range(0, 31)), $urandom());
        end
        $display("[TB] random run done db=%h rise=%h fall=%h", rv[1], rv[2], rv[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
